// File: rtl/excess_3_pkg.sv
// Shared constants for the BCD <-> excess-3 digit converter.
// Latency: n/a (constants only).
// Backpressure: n/a.
package excess_3_pkg;

   // Conversion direction, sampled with each nibble
   localparam logic MODE_ENC = 1'b0;
   localparam logic MODE_DEC = 1'b1;

   // Offset between 8421 BCD and excess-3
   localparam logic [3:0] XS3_BIAS = 4'd3;

   // Legal code ranges on the input side of each direction
   localparam logic [3:0] BCD_MAX = 4'd9;
   localparam logic [3:0] XS3_MIN = 4'd3;
   localparam logic [3:0] XS3_MAX = 4'd12;

endpackage

// File: rtl/excess_3_if.sv
// Digit bus into and out of the excess-3 converter stage.
// Latency: n/a (signal bundle only).
// Backpressure: none; the producer may present a nibble every cycle.
interface excess_3_if #(
   parameter int CNT_W = 8
);

   // Input nibble {a,b,c,d}, qualifier and direction
   logic             a;
   logic             b;
   logic             c;
   logic             d;
   logic             in_valid;
   logic             mode;

   // Result nibble {w,x,y,z}, qualifier and error status
   logic             w;
   logic             x;
   logic             y;
   logic             z;
   logic             out_valid;
   logic             err;
   logic [CNT_W-1:0] err_count;

   // Producer side: drives the nibble, observes the result
   modport master (
      output a, b, c, d, in_valid, mode,
      input  w, x, y, z, out_valid, err, err_count
   );

   // Converter side: consumes the nibble, drives the result
   modport slave (
      input  a, b, c, d, in_valid, mode,
      output w, x, y, z, out_valid, err, err_count
   );

endinterface

// File: rtl/excess_3_core.sv
// Combinational BCD <-> excess-3 conversion with illegal-code detection.
// Latency: 0 cycles (pure logic).
// Backpressure: none.
module excess_3_core
   import excess_3_pkg::*;
(
   input  logic [3:0] nib,
   input  logic       mode,
   output logic [3:0] res,
   output logic       illegal
);

   // Pick the legal range for the direction, then add or remove the bias;
   // an illegal code forces a zero result so stale arithmetic never leaks out
   always_comb begin
      res     = 4'd0;
      illegal = 1'b0;
      if (mode == MODE_ENC) begin
         if (nib > BCD_MAX) begin
            illegal = 1'b1;
         end else begin
            res = nib + XS3_BIAS;
         end
      end else begin
         if ((nib < XS3_MIN) || (nib > XS3_MAX)) begin
            illegal = 1'b1;
         end else begin
            res = nib - XS3_BIAS;
         end
      end
   end

endmodule

// File: rtl/excess_3.sv
// Registered BCD <-> excess-3 digit converter with saturating illegal-code counter.
// Latency: 1 cycle from in_valid to out_valid; one nibble per cycle.
// Backpressure: none; result and err hold while in_valid is low.
module excess_3
   import excess_3_pkg::*;
#(
   parameter int CNT_W = 8
) (
   input  logic        clk,
   input  logic        rst,
   excess_3_if.slave   io
);

   logic [3:0]       core_res;
   logic             core_illegal;
   logic [3:0]       res_q;
   logic             err_q;
   logic             vld_q;
   logic [CNT_W-1:0] err_cnt_q;

   excess_3_core u_core (
      .nib     ({io.a, io.b, io.c, io.d}),
      .mode    (io.mode),
      .res     (core_res),
      .illegal (core_illegal)
   );

   // Output stage: capture result on valid input, otherwise hold data and drop valid
   always_ff @(posedge clk) begin
      if (rst) begin
         res_q <= 4'd0;
         err_q <= 1'b0;
         vld_q <= 1'b0;
      end else if (io.in_valid) begin
         res_q <= core_res;
         err_q <= core_illegal;
         vld_q <= 1'b1;
      end else begin
         vld_q <= 1'b0;
      end
   end

   // Illegal-code counter steps with err and sticks at all-ones
   always_ff @(posedge clk) begin
      if (rst) begin
         err_cnt_q <= '0;
      end else if (io.in_valid && core_illegal && (err_cnt_q != '1)) begin
         err_cnt_q <= err_cnt_q + CNT_W'(1);
      end
   end

   assign io.w         = res_q[3];
   assign io.x         = res_q[2];
   assign io.y         = res_q[1];
   assign io.z         = res_q[0];
   assign io.out_valid = vld_q;
   assign io.err       = err_q;
   assign io.err_count = err_cnt_q;

endmodule

// File: tb/tb_excess_3.sv
// Directed bench for excess_3: default counter width plus a 2-bit counter instance.
// Latency: checks one cycle after each driven edge.
// Backpressure: none exercised; the design has none.
module tb_excess_3;

   logic clk;
   logic rst;
   int   n_tests;
   int   n_fail;

   excess_3_if #(.CNT_W(8)) bus8 ();
   excess_3_if #(.CNT_W(2)) bus2 ();

   excess_3 #(.CNT_W(8)) dut8 (
      .clk (clk),
      .rst (rst),
      .io  (bus8)
   );

   excess_3 #(.CNT_W(2)) dut2 (
      .clk (clk),
      .rst (rst),
      .io  (bus2)
   );

   // 10 ns clock
   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   // Single comparison point for every check
   task automatic chk(input string tag, input int obs, input int exp);
      n_tests++;
      if (obs != exp) begin
         n_fail++;
         $display("FAIL %s: got %0d, want %0d", tag, obs, exp);
      end
   endtask

   function automatic int res8();
      return int'({bus8.w, bus8.x, bus8.y, bus8.z});
   endfunction

   // Drive both instances on the falling edge, then sample 1 ns after the rising edge
   task automatic step(input logic r, input logic v, input logic m, input logic [3:0] n);
      @(negedge clk);
      rst           = r;
      bus8.in_valid = v;
      bus8.mode     = m;
      {bus8.a, bus8.b, bus8.c, bus8.d} = n;
      bus2.in_valid = v;
      bus2.mode     = m;
      {bus2.a, bus2.b, bus2.c, bus2.d} = n;
      @(posedge clk);
      #1;
   endtask

   int enc_exp [10] = '{3, 4, 5, 6, 7, 8, 9, 10, 11, 12};
   int sat_exp [5]  = '{1, 2, 3, 3, 3};

   initial begin
      n_tests = 0;
      n_fail  = 0;
      rst = 1'b1;
      bus8.in_valid = 1'b0; bus8.mode = 1'b0;
      {bus8.a, bus8.b, bus8.c, bus8.d} = 4'd0;
      bus2.in_valid = 1'b0; bus2.mode = 1'b0;
      {bus2.a, bus2.b, bus2.c, bus2.d} = 4'd0;

      // Reset state
      step(1'b1, 1'b0, 1'b0, 4'd0);
      step(1'b1, 1'b0, 1'b0, 4'd0);
      chk("rst_res", res8(), 0);
      chk("rst_vld", int'(bus8.out_valid), 0);
      chk("rst_err", int'(bus8.err), 0);
      chk("rst_cnt", int'(bus8.err_count), 0);
      chk("rst_cnt2", int'(bus2.err_count), 0);

      // Encode sweep 0..9
      for (int i = 0; i < 10; i++) begin
         step(1'b0, 1'b1, 1'b0, 4'(i));
         chk($sformatf("enc%0d_res", i), res8(), enc_exp[i]);
         chk($sformatf("enc%0d_err", i), int'(bus8.err), 0);
         chk($sformatf("enc%0d_vld", i), int'(bus8.out_valid), 1);
      end

      // Encode illegal codes
      step(1'b0, 1'b1, 1'b0, 4'b1010);
      chk("enc_ill10_res", res8(), 0);
      chk("enc_ill10_err", int'(bus8.err), 1);
      chk("enc_ill10_cnt", int'(bus8.err_count), 1);
      step(1'b0, 1'b1, 1'b0, 4'b1111);
      chk("enc_ill15_res", res8(), 0);
      chk("enc_ill15_err", int'(bus8.err), 1);
      chk("enc_ill15_cnt", int'(bus8.err_count), 2);

      // Decode round trip and boundaries
      step(1'b0, 1'b1, 1'b0, 4'd7);
      chk("rt_enc7", res8(), 10);
      step(1'b0, 1'b1, 1'b1, 4'b1010);
      chk("rt_dec_res", res8(), 7);
      chk("rt_dec_err", int'(bus8.err), 0);
      chk("rt_dec_cnt", int'(bus8.err_count), 2);
      step(1'b0, 1'b1, 1'b1, 4'd3);
      chk("dec3_res", res8(), 0);
      chk("dec3_err", int'(bus8.err), 0);
      step(1'b0, 1'b1, 1'b1, 4'd12);
      chk("dec12_res", res8(), 9);
      chk("dec12_err", int'(bus8.err), 0);
      step(1'b0, 1'b1, 1'b1, 4'b0010);
      chk("dec2_res", res8(), 0);
      chk("dec2_err", int'(bus8.err), 1);
      chk("dec2_cnt", int'(bus8.err_count), 3);
      step(1'b0, 1'b1, 1'b1, 4'd13);
      chk("dec13_err", int'(bus8.err), 1);
      chk("dec13_cnt", int'(bus8.err_count), 4);

      // Valid gap: result holds, valid drops, junk on the bus is ignored
      step(1'b0, 1'b1, 1'b0, 4'd5);
      chk("gap_first_res", res8(), 8);
      chk("gap_first_vld", int'(bus8.out_valid), 1);
      for (int i = 0; i < 3; i++) begin
         step(1'b0, 1'b0, 1'b1, 4'd15);
         chk($sformatf("gap%0d_vld", i), int'(bus8.out_valid), 0);
         chk($sformatf("gap%0d_res", i), res8(), 8);
         chk($sformatf("gap%0d_err", i), int'(bus8.err), 0);
         chk($sformatf("gap%0d_cnt", i), int'(bus8.err_count), 4);
      end

      // Reset wins over a valid nibble on the same edge
      step(1'b1, 1'b1, 1'b0, 4'd9);
      chk("rp_res", res8(), 0);
      chk("rp_vld", int'(bus8.out_valid), 0);
      chk("rp_err", int'(bus8.err), 0);
      chk("rp_cnt", int'(bus8.err_count), 0);
      step(1'b0, 1'b0, 1'b0, 4'd9);
      chk("rp_idle_vld", int'(bus8.out_valid), 0);
      chk("rp_idle_res", res8(), 0);
      step(1'b0, 1'b1, 1'b0, 4'd9);
      chk("rp_next_vld", int'(bus8.out_valid), 1);
      chk("rp_next_res", res8(), 12);
      chk("rp_cnt2", int'(bus2.err_count), 0);

      // Saturation: 2-bit counter stops at 3, 8-bit keeps counting
      for (int i = 0; i < 5; i++) begin
         step(1'b0, 1'b1, 1'b0, 4'd15);
         chk($sformatf("sat%0d_cnt2", i), int'(bus2.err_count), sat_exp[i]);
         chk($sformatf("sat%0d_cnt8", i), int'(bus8.err_count), i + 1);
         chk($sformatf("sat%0d_err2", i), int'(bus2.err), 1);
      end

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

   // Guard against a stalled run
   initial begin
      #100000;
      $display("FAIL watchdog: simulation time limit reached, tests=%0d", n_tests);
      $fatal(1, "watchdog");
   end

endmodule
